// File: rtl/crypto_pkg.sv
// Shared definitions for the encrypt/decrypt lanes: round constant, rotate and round-key helpers.
// Latency: none (types, constants and combinational functions only).
// Backpressure: not applicable.
package crypto_pkg;

    localparam logic [31:0] ROUND_CONST = 32'h9E3779B9;
    localparam int unsigned ROT_DEFAULT = 5;

    // Helpers work on a 64-bit container so one function set serves any
    // BLOCK_WIDTH up to 64; callers cast the result back to their width.
    localparam int unsigned WORD_MAX = 64;
    typedef logic [WORD_MAX-1:0] word_t;

    localparam int unsigned LANE_DATA_W = 32;
    localparam int unsigned LANE_SEQ_W  = 8;

    typedef struct packed {
        logic [LANE_DATA_W-1:0] data;
        logic [LANE_SEQ_W-1:0]  seq_id;
    } lane_beat_t;

    typedef enum logic [1:0] {
        NO_KEY = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2
    } lane_state_t;

    function automatic word_t width_mask(input int unsigned w);
        if (w >= WORD_MAX) begin
            return '1;
        end
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t rotl(input word_t x, input int unsigned n, input int unsigned w);
        word_t       xm;
        int unsigned s;
        xm = x & width_mask(w);
        s  = n % w;
        if (s == 0) begin
            return xm;
        end
        return ((xm << s) | (xm >> (w - s))) & width_mask(w);
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n, input int unsigned w);
        return rotl(x, w - (n % w), w);
    endfunction

    // rk[r] = rotl(key, r) ^ low w bits of (r * ROUND_CONST)
    function automatic word_t round_key(input word_t key, input int unsigned r, input int unsigned w);
        return rotl(key, r, w) ^ ((word_t'(r) * word_t'(ROUND_CONST)) & width_mask(w));
    endfunction

endpackage

// File: rtl/decryption_lane_if.sv
// Handshake bundle of one decryption lane: key load, ciphertext in, plaintext out, busy.
// Latency: none (wires only).
// Backpressure: valid/ready on key, input and output; master drives requests, slave is the lane.
interface decryption_lane_if #(
    parameter int unsigned BLOCK_WIDTH       = 32,
    parameter int unsigned SEQUENCE_ID_WIDTH = 8
);
    logic [BLOCK_WIDTH-1:0]       key_in;
    logic                         key_valid;
    logic                         key_ready;
    logic [BLOCK_WIDTH-1:0]       data_in;
    logic [SEQUENCE_ID_WIDTH-1:0] seq_id_in;
    logic                         data_in_valid;
    logic                         data_in_ready;
    logic [BLOCK_WIDTH-1:0]       data_out;
    logic [SEQUENCE_ID_WIDTH-1:0] seq_id_out;
    logic                         data_out_valid;
    logic                         data_out_ready;
    logic                         busy;

    modport master (
        output key_in, key_valid, data_in, seq_id_in, data_in_valid, data_out_ready,
        input  key_ready, data_in_ready, data_out, seq_id_out, data_out_valid, busy
    );

    modport slave (
        input  key_in, key_valid, data_in, seq_id_in, data_in_valid, data_out_ready,
        output key_ready, data_in_ready, data_out, seq_id_out, data_out_valid, busy
    );
endinterface

// File: rtl/decrypt_round_stage.sv
// One inverse round plus its pipeline register: data <= rotr(up_data, ROT) ^ rk.
// Latency: 1 cycle per stage.
// Backpressure: adv = !valid | down_adv, so an empty stage always loads (bubbles collapse).
// Ports: up_* from the previous stage (or lane input), rk round key, down_adv from the next
//        stage, valid/data/seq_id the registered stage contents, adv this stage's advance.
module decrypt_round_stage
    import crypto_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH       = 32,
    parameter int unsigned SEQUENCE_ID_WIDTH = 8,
    parameter int unsigned ROT               = ROT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_valid,
    input  logic [BLOCK_WIDTH-1:0]       up_data,
    input  logic [SEQUENCE_ID_WIDTH-1:0] up_seq_id,
    input  logic [BLOCK_WIDTH-1:0]       rk,
    input  logic                         down_adv,
    output logic                         valid,
    output logic [BLOCK_WIDTH-1:0]       data,
    output logic [SEQUENCE_ID_WIDTH-1:0] seq_id,
    output logic                         adv
);

    logic [BLOCK_WIDTH-1:0] plain;

    assign adv   = !valid || down_adv;
    assign plain = BLOCK_WIDTH'(rotr(word_t'(up_data), ROT, BLOCK_WIDTH)) ^ rk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            data   <= '0;
            seq_id <= '0;
        end else if (adv) begin
            valid <= up_valid;
            // Payload only moves with a real block so a bubble never disturbs it.
            if (up_valid) begin
                data   <= plain;
                seq_id <= up_seq_id;
            end
        end
    end

endmodule

// File: rtl/decryption_lane.sv
// Pipelined inverse of encryption_lane with sequence-ID passthrough and runtime rekey.
// Latency: DECRYPT_LATENCY cycles accept-to-output, 1 block/cycle when unstalled.
// Backpressure: data_out_ready stalls the last stage; bubbles collapse, input stalls once full.
// Ports: clk/rst (async active-high); lane = key load, ciphertext in, plaintext out, busy.
//        A key request blocks new input; it is granted only once the pipeline is empty.
module decryption_lane
    import crypto_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH       = 32,
    parameter int unsigned SEQUENCE_ID_WIDTH = 8,
    parameter int unsigned DECRYPT_LATENCY   = 8,
    parameter int unsigned ROT               = ROT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    decryption_lane_if.slave  lane
);

    localparam int unsigned L = DECRYPT_LATENCY;

    lane_state_t                  state;
    lane_state_t                  state_nx;
    logic                         key_load;
    logic [BLOCK_WIDTH-1:0]       key_q;
    logic [L-1:0]                 stg_valid;
    logic [L:0]                   adv;
    logic [BLOCK_WIDTH-1:0]       stg_data [L];
    logic [SEQUENCE_ID_WIDTH-1:0] stg_seq  [L];
    logic                         busy;

    assign busy   = |stg_valid;
    assign adv[L] = lane.data_out_ready;

    // A pending key request closes the input even before DRAIN is entered,
    // so a block can never slip in under a key that is about to change.
    assign lane.data_in_ready  = (state == RUN) && !lane.key_valid && adv[0];
    assign lane.key_ready      = key_load;
    assign lane.busy           = busy;
    assign lane.data_out       = stg_data[L-1];
    assign lane.seq_id_out     = stg_seq[L-1];
    assign lane.data_out_valid = stg_valid[L-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NO_KEY;
            key_q <= '0;
        end else begin
            state <= state_nx;
            if (key_load) begin
                key_q <= lane.key_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        key_load = 1'b0;
        case (state)
            NO_KEY: begin
                if (lane.key_valid) begin
                    key_load = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (lane.key_valid) begin
                    if (busy) begin
                        state_nx = DRAIN;
                    end else begin
                        key_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!lane.key_valid) begin
                    // Requester withdrew: resume with the old key.
                    state_nx = RUN;
                end else if (!busy) begin
                    key_load = 1'b1;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = NO_KEY;
            end
        endcase
    end

    // Stage j undoes encrypt round L-1-j, so the first stage uses the last round key.
    for (genvar j = 0; j < L; j++) begin : g_stage
        localparam int unsigned RIDX = L - 1 - j;

        logic                         up_valid;
        logic [BLOCK_WIDTH-1:0]       up_data;
        logic [SEQUENCE_ID_WIDTH-1:0] up_seq_id;
        logic [BLOCK_WIDTH-1:0]       rk;

        assign rk = BLOCK_WIDTH'(round_key(word_t'(key_q), RIDX, BLOCK_WIDTH));

        if (j == 0) begin : g_head
            assign up_valid  = lane.data_in_valid && lane.data_in_ready;
            assign up_data   = lane.data_in;
            assign up_seq_id = lane.seq_id_in;
        end else begin : g_body
            assign up_valid  = stg_valid[j-1];
            assign up_data   = stg_data[j-1];
            assign up_seq_id = stg_seq[j-1];
        end

        decrypt_round_stage #(
            .BLOCK_WIDTH       (BLOCK_WIDTH),
            .SEQUENCE_ID_WIDTH (SEQUENCE_ID_WIDTH),
            .ROT               (ROT)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_valid  (up_valid),
            .up_data   (up_data),
            .up_seq_id (up_seq_id),
            .rk        (rk),
            .down_adv  (adv[j+1]),
            .valid     (stg_valid[j]),
            .data      (stg_data[j]),
            .seq_id    (stg_seq[j]),
            .adv       (adv[j])
        );
    end

endmodule

// File: tb/tb_decryption_lane.sv
// Self-checking bench: hand vectors on a 1-stage lane, encrypt-model streams on an 8-stage lane.
// Latency: not applicable.
// Backpressure: bench toggles data_out_ready and key_valid to exercise stalls and rekey.
module tb_decryption_lane;
    import crypto_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    decryption_lane_if #(.BLOCK_WIDTH(32), .SEQUENCE_ID_WIDTH(8)) if1 ();
    decryption_lane_if #(.BLOCK_WIDTH(32), .SEQUENCE_ID_WIDTH(8)) if8 ();

    decryption_lane #(.BLOCK_WIDTH(32), .SEQUENCE_ID_WIDTH(8), .DECRYPT_LATENCY(1), .ROT(5))
        dut1 (.clk(clk), .rst(rst), .lane(if1));
    decryption_lane #(.BLOCK_WIDTH(32), .SEQUENCE_ID_WIDTH(8), .DECRYPT_LATENCY(8), .ROT(5))
        dut8 (.clk(clk), .rst(rst), .lane(if8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Forward cipher, written independently from the lane's inverse rounds.
    function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] m_encrypt(input logic [31:0] pt, input logic [31:0] key, input int rounds);
        logic [31:0] x;
        logic [31:0] rk;
        x = pt;
        for (int r = 0; r < rounds; r++) begin
            rk = m_rotl(key, r) ^ (32'(r) * 32'h9E3779B9);
            x  = m_rotl(x ^ rk, 5);
        end
        return x;
    endfunction

    // Scoreboard on the 8-stage lane: every output transfer pops one expected beat.
    lane_beat_t exp_q[$];
    int out_cnt       = 0;
    int first_out_cyc = 0;
    int last_out_cyc  = 0;

    always @(negedge clk) begin
        lane_beat_t e;
        if (!rst && if8.data_out_valid && if8.data_out_ready) begin
            check("sb_q_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_dat", 64'(if8.data_out), 64'(e.data));
                check("sb_tag", 64'(if8.seq_id_out), 64'(e.seq_id));
            end
            if (out_cnt == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_cnt++;
        end
    end

    // Per-cycle stream driver; optional input gap [gap_lo,gap_hi) and output stall [stall_lo,stall_hi).
    task automatic stream8(input int n, input logic [31:0] key, input int tag0,
                           input int gap_lo, input int gap_hi, input int stall_lo, input int stall_hi,
                           input int exp_stall_acc, output int not_rdy, output int first_acc);
        int          sent;
        int          k;
        int          stall_acc;
        logic [31:0] pt;
        logic [31:0] hold_d;
        logic [7:0]  hold_s;
        logic        stalled;
        lane_beat_t  e;
        sent = 0; k = 0; stall_acc = 0; not_rdy = 0; first_acc = -1;
        hold_d = '0; hold_s = '0;
        pt = $urandom;
        while ((sent < n || exp_q.size() != 0) && k < 3000) begin
            stalled = (k >= stall_lo) && (k < stall_hi);
            if8.data_out_ready = !stalled;
            if8.data_in_valid  = (sent < n) && !((k >= gap_lo) && (k < gap_hi));
            if8.data_in        = m_encrypt(pt, key, 8);
            if8.seq_id_in      = 8'(tag0 + sent);
            #1;
            if (stalled && k == stall_lo) begin
                hold_d = if8.data_out;
                hold_s = if8.seq_id_out;
            end
            if (stalled && k == stall_hi - 1) begin
                check("stall_hold_vld", 64'(if8.data_out_valid), 64'(1));
                check("stall_hold_dat", 64'(if8.data_out), 64'(hold_d));
                check("stall_hold_tag", 64'(if8.seq_id_out), 64'(hold_s));
                check("stall_in_rdy", 64'(if8.data_in_ready), 64'(0));
                check("stall_fill", 64'(stall_acc), 64'(exp_stall_acc));
            end
            if (if8.data_in_valid && if8.data_in_ready) begin
                e.data   = pt;
                e.seq_id = 8'(tag0 + sent);
                exp_q.push_back(e);
                if (sent == 0) first_acc = cyc;
                if (stalled) stall_acc++;
                sent++;
                pt = $urandom;
            end else if (if8.data_in_valid) begin
                not_rdy++;
            end
            @(posedge clk); #1;
            k++;
        end
        if8.data_in_valid  = 1'b0;
        if8.data_out_ready = 1'b1;
        check("stream_done", 64'(k < 3000), 64'(1));
    endtask

    initial begin
        logic [31:0] ka, kb, kc, kd, pt;
        int          nr, fa, n, bad_rdy;
        logic        got, prev_busy;
        lane_beat_t  e;

        if1.key_in = '0; if1.key_valid = 1'b0; if1.data_in = '0; if1.seq_id_in = '0;
        if1.data_in_valid = 1'b0; if1.data_out_ready = 1'b1;
        if8.key_in = '0; if8.key_valid = 1'b0; if8.data_in = '0; if8.seq_id_in = '0;
        if8.data_in_valid = 1'b0; if8.data_out_ready = 1'b1;
        ka = $urandom; kb = $urandom; kc = $urandom; kd = $urandom;

        // Reset state
        #2;
        check("rst_out_vld", 64'(if8.data_out_valid), 64'(0));
        check("rst_out_dat", 64'(if8.data_out), 64'(0));
        check("rst_out_tag", 64'(if8.seq_id_out), 64'(0));
        check("rst_busy", 64'(if8.busy), 64'(0));
        check("rst_in_rdy", 64'(if8.data_in_ready), 64'(0));
        check("rst_key_rdy", 64'(if8.key_ready), 64'(0));
        check("rst_l1_vld", 64'(if1.data_out_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        if8.data_in_valid = 1'b1;
        #1;
        check("nokey_in_rdy", 64'(if8.data_in_ready), 64'(0));
        check("nokey_key_rdy", 64'(if8.key_ready), 64'(0));
        if8.data_in_valid = 1'b0;
        @(posedge clk); #1;

        // Test 1: L=1, key 0, 0x20 -> 0x1 one cycle after accept
        if1.key_in = 32'h0; if1.key_valid = 1'b1;
        #1; check("t1_key_rdy", 64'(if1.key_ready), 64'(1));
        @(posedge clk); #1;
        if1.key_valid = 1'b0;
        if1.data_in = 32'h0000_0020; if1.seq_id_in = 8'h07; if1.data_in_valid = 1'b1;
        #1; check("t1_in_rdy", 64'(if1.data_in_ready), 64'(1));
        @(posedge clk); #1;
        if1.data_in_valid = 1'b0;
        check("t1_out_vld", 64'(if1.data_out_valid), 64'(1));
        check("t1_out_dat", 64'(if1.data_out), 64'h1);
        check("t1_out_tag", 64'(if1.seq_id_out), 64'h07);

        // Test 2: rekey to 0xFF while the block is still in the stage, then 0x20 -> 0xFE
        if1.key_in = 32'h0000_00FF; if1.key_valid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 10) begin
            #1;
            if (if1.key_ready) got = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("t2_key_rdy", 64'(got), 64'(1));
        check("t2_drain_cycles", 64'(n), 64'(2));
        if1.key_valid = 1'b0;
        if1.data_in = 32'h0000_0020; if1.seq_id_in = 8'h08; if1.data_in_valid = 1'b1;
        #1; check("t2_in_rdy", 64'(if1.data_in_ready), 64'(1));
        @(posedge clk); #1;
        if1.data_in_valid = 1'b0;
        check("t2_out_vld", 64'(if1.data_out_valid), 64'(1));
        check("t2_out_dat", 64'(if1.data_out), 64'h0000_00FE);
        check("t2_out_tag", 64'(if1.seq_id_out), 64'h08);

        // Load key A into the 8-stage lane
        if8.key_in = ka; if8.key_valid = 1'b1;
        #1; check("l8_key_rdy", 64'(if8.key_ready), 64'(1));
        @(posedge clk); #1;
        if8.key_valid = 1'b0;

        // Test 3: 256 back-to-back blocks, tags 0..255
        out_cnt = 0;
        stream8(256, ka, 0, 0, 0, 0, 0, 0, nr, fa);
        check("t3_no_in_stall", 64'(nr), 64'(0));
        check("t3_latency", 64'(first_out_cyc - fa), 64'(8));
        check("t3_span", 64'(last_out_cyc - first_out_cyc), 64'(255));
        check("t3_count", 64'(out_cnt), 64'(256));

        // Test 4: input gap then 20-cycle output stall; 4 bubbles get filled before input stops
        out_cnt = 0;
        stream8(40, ka, 0, 6, 10, 10, 30, 4, nr, fa);
        check("t4_count", 64'(out_cnt), 64'(40));

        // Test 5: key request with 5 blocks in flight
        out_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            pt = $urandom;
            if8.data_in = m_encrypt(pt, ka, 8); if8.seq_id_in = 8'(100 + i); if8.data_in_valid = 1'b1;
            #1; check("t5_pre_rdy", 64'(if8.data_in_ready), 64'(1));
            if (if8.data_in_ready) begin
                e.data = pt; e.seq_id = 8'(100 + i);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        if8.key_in = kb; if8.key_valid = 1'b1;
        if8.data_in = m_encrypt($urandom, kb, 8); if8.seq_id_in = 8'd105;
        got = 1'b0; n = 0; bad_rdy = 0; prev_busy = 1'b0;
        while (!got && n < 50) begin
            #1;
            if (if8.key_ready) begin
                got = 1'b1;
                check("t5_busy_fell", 64'({prev_busy, if8.busy}), 64'(2'b10));
                check("t5_kr_no_acc", 64'(if8.data_in_ready), 64'(0));
                check("t5_drained", 64'(exp_q.size()), 64'(0));
            end else begin
                if (if8.data_in_ready) bad_rdy++;
                prev_busy = if8.busy;
            end
            @(posedge clk); #1;
            n++;
        end
        check("t5_kr_seen", 64'(got), 64'(1));
        check("t5_in_blocked", 64'(bad_rdy), 64'(0));
        check("t5_old_key_cnt", 64'(out_cnt), 64'(5));
        if8.key_valid = 1'b0;
        stream8(6, kb, 110, 0, 0, 0, 0, 0, nr, fa);
        check("t5_new_key_cnt", 64'(out_cnt), 64'(11));

        // Simultaneous key and data in RUN with an empty pipeline: key wins
        if8.key_in = kc; if8.key_valid = 1'b1; if8.data_in_valid = 1'b1;
        #1;
        check("sim_key_rdy", 64'(if8.key_ready), 64'(1));
        check("sim_in_rdy", 64'(if8.data_in_ready), 64'(0));
        @(posedge clk); #1;
        if8.key_valid = 1'b0; if8.data_in_valid = 1'b0;
        check("sim_no_data", 64'(if8.busy), 64'(0));

        // Test 6: async reset with the pipeline full
        if8.data_out_ready = 1'b0; if8.data_in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if8.data_in = $urandom; if8.seq_id_in = 8'(i);
            @(posedge clk); #1;
        end
        #1;
        check("t6_full_busy", 64'(if8.busy), 64'(1));
        check("t6_full_in_rdy", 64'(if8.data_in_ready), 64'(0));
        #1; rst = 1'b1;
        #1;
        check("t6_rst_vld", 64'(if8.data_out_valid), 64'(0));
        check("t6_rst_dat", 64'(if8.data_out), 64'(0));
        check("t6_rst_tag", 64'(if8.seq_id_out), 64'(0));
        check("t6_rst_busy", 64'(if8.busy), 64'(0));
        check("t6_rst_in_rdy", 64'(if8.data_in_ready), 64'(0));
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        if8.data_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_nokey_in_rdy", 64'(if8.data_in_ready), 64'(0));
            check("t6_nokey_vld", 64'(if8.data_out_valid), 64'(0));
            @(posedge clk); #1;
        end
        if8.data_in_valid = 1'b0;
        if8.key_in = kd; if8.key_valid = 1'b1;
        #1; check("t6_key_rdy", 64'(if8.key_ready), 64'(1));
        @(posedge clk); #1;
        if8.key_valid = 1'b0;
        exp_q.delete();
        out_cnt = 0;
        stream8(5, kd, 200, 0, 0, 0, 0, 0, nr, fa);
        check("t6_after_cnt", 64'(out_cnt), 64'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 64'(0), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
